// File: rtl/t03_hline_tracker_pkg.sv
// Shared state type and default sizing for the horizontal line tracker.
package t03_hline_pkg;
    localparam int W_DEF       = 11;
    localparam int MIN_LEN_DEF = 16;
    localparam int MAX_LEN_DEF = 1024;
    localparam int MAX_ERR_DEF = 3;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;
endpackage

// File: rtl/t03_hline_tracker_if.sv
// Line-timing link between the horizontal counter (master) and the tracker (slave).
interface t03_hline_tracker_if
    import t03_hline_pkg::*;
#(
    parameter int W = W_DEF
);
    logic         tc_in;
    logic         locked;
    logic [W-1:0] hpos;
    logic [W-1:0] line_len;
    logic         line_start;
    logic         err;

    modport master (output tc_in, input locked, hpos, line_len, line_start, err);
    modport slave  (input tc_in, output locked, hpos, line_len, line_start, err);
endinterface

// File: rtl/t03_hline_tracker.sv
// Locks onto the horizontal line strobe period and flywheels a local pixel
// position aligned to the transmitter's count once two equal periods are seen.
//
// state   | meaning
// --------+-----------------------------------------------------------
// SEARCH  | waiting for any strobe to start a period measurement
// MEASURE | counting strobe-to-strobe periods, holding a candidate
// LOCKED  | flywheeling hpos over line_len, checking strobe alignment
module t03_hline_tracker
    import t03_hline_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int MIN_LEN = MIN_LEN_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int MAX_ERR = MAX_ERR_DEF
) (
    input  logic              clk,
    input  logic              nrst,
    t03_hline_tracker_if.slave hl
);
    localparam int           EW    = $clog2(MAX_ERR + 1);
    localparam logic [W-1:0] MIN_L = W'(MIN_LEN);
    localparam logic [W-1:0] MAX_L = W'(MAX_LEN);
    localparam logic [EW-1:0] MAX_E = EW'(MAX_ERR);

    state_t        state_q, state_d;
    logic [W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]  cand_q, cand_d;
    logic          cand_valid_q, cand_valid_d;
    logic [W-1:0]  hpos_q, hpos_d;
    logic [W-1:0]  line_len_q, line_len_d;
    logic [EW-1:0] err_cnt_q, err_cnt_d;
    logic          err_q, err_d;

    logic [EW-1:0] err_cnt_inc;
    logic          hpos_zero;

    assign err_cnt_inc = err_cnt_q + EW'(1);
    assign hpos_zero   = (hpos_q == '0);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= SEARCH;
            cnt_q        <= '0;
            cand_q       <= '0;
            cand_valid_q <= 1'b0;
            hpos_q       <= '0;
            line_len_q   <= '0;
            err_cnt_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cand_q       <= cand_d;
            cand_valid_q <= cand_valid_d;
            hpos_q       <= hpos_d;
            line_len_q   <= line_len_d;
            err_cnt_q    <= err_cnt_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cand_d       = cand_q;
        cand_valid_d = cand_valid_q;
        hpos_d       = hpos_q;
        line_len_d   = line_len_q;
        err_cnt_d    = err_cnt_q;
        err_d        = 1'b0;

        unique case (state_q)
            SEARCH: begin
                hpos_d     = '0;
                line_len_d = '0;
                if (hl.tc_in) begin
                    state_d      = MEASURE;
                    cnt_d        = W'(1);
                    cand_valid_d = 1'b0;
                end
            end

            MEASURE: begin
                if (hl.tc_in) begin
                    cnt_d = W'(1);
                    if (cnt_q < MIN_L || cnt_q > MAX_L) begin
                        cand_valid_d = 1'b0;
                    end else if (!cand_valid_q || cnt_q != cand_q) begin
                        cand_d       = cnt_q;
                        cand_valid_d = 1'b1;
                    end else begin
                        state_d    = LOCKED;
                        line_len_d = cand_q;
                        hpos_d     = W'(1);
                        err_cnt_d  = '0;
                    end
                end else if (cnt_q == MAX_L) begin
                    // no strobe within the longest legal line: start over
                    state_d = SEARCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end

            LOCKED: begin
                hpos_d = (hpos_q == line_len_q - W'(1)) ? '0 : hpos_q + W'(1);
                if (hl.tc_in && hpos_zero) begin
                    err_cnt_d = '0;
                end else if (hl.tc_in || hpos_zero) begin
                    // misplaced or missing strobe; the flywheel is never resynced
                    err_d     = 1'b1;
                    err_cnt_d = err_cnt_inc;
                    if (err_cnt_inc == MAX_E) begin
                        state_d    = SEARCH;
                        hpos_d     = '0;
                        line_len_d = '0;
                    end
                end
            end

            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    always_comb begin
        hl.locked     = (state_q == LOCKED);
        hl.hpos       = hpos_q;
        hl.line_len   = line_len_q;
        hl.err        = err_q;
        hl.line_start = (state_q == LOCKED) && hpos_zero;
    end
endmodule

// File: tb/tb_t03_hline_tracker.sv
// Randomized and directed line-strobe stimulus against a timestamp-based
// reference model; expected outputs are queued and checked by a monitor.
module tb_t03_hline_tracker;
    localparam int W     = 11;
    localparam int P_MIN = 16;
    localparam int P_MAX = 1024;
    localparam int P_ERR = 3;

    typedef struct packed {
        logic         locked;
        logic [W-1:0] hpos;
        logic [W-1:0] line_len;
        logic         line_start;
        logic         err;
    } obs_t;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    t03_hline_tracker_if #(.W(W)) hl();

    t03_hline_tracker #(
        .W(W), .MIN_LEN(P_MIN), .MAX_LEN(P_MAX), .MAX_ERR(P_ERR)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .hl  (hl)
    );

    obs_t   exp_q[$];
    int     tests_run    = 0;
    int     tests_failed = 0;
    int     err_seen     = 0;
    longint t_now        = 0;

    // reference model: mode 0 search, 1 measure, 2 locked; all timing from timestamps
    int     m_mode;
    longint m_last;
    longint m_lock_t;
    int     m_cand;
    bit     m_cv;
    int     m_len;
    int     m_errs;

    task model_reset();
        m_mode = 0; m_cv = 0; m_len = 0; m_errs = 0; m_cand = 0;
        m_last = 0; m_lock_t = 0;
    endtask

    task model_step(input bit tc);
        bit     e;
        int     pos;
        longint el;
        obs_t   o;
        e = 1'b0;
        case (m_mode)
            0: if (tc) begin m_mode = 1; m_last = t_now; m_cv = 0; end
            1: begin
                el = t_now - m_last;
                if (tc) begin
                    if (el < P_MIN || el > P_MAX) begin
                        m_cv = 0; m_last = t_now;
                    end else if (!m_cv || el != longint'(m_cand)) begin
                        m_cand = int'(el); m_cv = 1; m_last = t_now;
                    end else begin
                        m_mode = 2; m_len = m_cand; m_lock_t = t_now; m_errs = 0;
                    end
                end else if (el >= P_MAX) begin
                    m_mode = 0;
                end
            end
            default: begin
                pos = int'((t_now - m_lock_t) % m_len);
                if (tc && pos == 0) m_errs = 0;
                else if (tc || pos == 0) begin
                    e = 1'b1;
                    m_errs++;
                    if (m_errs == P_ERR) m_mode = 0;
                end
            end
        endcase
        o.locked     = (m_mode == 2);
        o.hpos       = o.locked ? W'((t_now + 1 - m_lock_t) % m_len) : '0;
        o.line_len   = o.locked ? W'(m_len) : '0;
        o.line_start = o.locked && (o.hpos == '0);
        o.err        = e;
        exp_q.push_back(o);
        t_now++;
    endtask

    always @(negedge clk) begin : monitor
        obs_t e_o, a_o;
        if (exp_q.size() > 0) begin
            e_o = exp_q.pop_front();
            a_o.locked     = hl.locked;
            a_o.hpos       = hl.hpos;
            a_o.line_len   = hl.line_len;
            a_o.line_start = hl.line_start;
            a_o.err        = hl.err;
            tests_run++;
            if (a_o.err === 1'b1) err_seen++;
            if (a_o !== e_o) begin
                tests_failed++;
                $display("FAIL out_cycle @%0t: got locked=%0b hpos=%0d len=%0d start=%0b err=%0b | want locked=%0b hpos=%0d len=%0d start=%0b err=%0b",
                         $time, a_o.locked, a_o.hpos, a_o.line_len, a_o.line_start, a_o.err,
                         e_o.locked, e_o.hpos, e_o.line_len, e_o.line_start, e_o.err);
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit v);
        hl.tc_in = v;
        @(posedge clk);
        model_step(v);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0);
    endtask

    task automatic strobe_after(input int gap);
        repeat (gap - 1) drive(1'b0);
        drive(1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        hl.tc_in = 1'b0;
        nrst     = 1'b0;
        #1;
        chk("rst_locked",   hl.locked,     0);
        chk("rst_hpos",     hl.hpos,       0);
        chk("rst_line_len", hl.line_len,   0);
        chk("rst_start",    hl.line_start, 0);
        chk("rst_err",      hl.err,        0);
        model_reset();
        @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    initial begin
        int e0;
        hl.tc_in = 1'b0;
        nrst     = 1'b1;
        model_reset();
        #1 nrst = 1'b0;
        #1;
        chk("init_locked",   hl.locked,     0);
        chk("init_hpos",     hl.hpos,       0);
        chk("init_line_len", hl.line_len,   0);
        chk("init_err",      hl.err,        0);
        @(posedge clk);
        #1 nrst = 1'b1;

        // lock at 209
        drive(1'b1);
        strobe_after(209);
        strobe_after(209);
        chk("lock209_locked", hl.locked,   1);
        chk("lock209_len",    hl.line_len, 209);
        chk("lock209_hpos",   hl.hpos,     1);
        repeat (3) strobe_after(209);

        // one dropped strobe
        e0 = err_seen;
        idle(209);
        strobe_after(209);
        chk("drop1_errs",   err_seen - e0, 1);
        chk("drop1_locked", hl.locked,     1);

        // two drops then a good strobe keeps lock
        strobe_after(209);
        e0 = err_seen;
        idle(418);
        strobe_after(209);
        chk("drop2_errs",   err_seen - e0, 2);
        chk("drop2_locked", hl.locked,     1);

        // extra strobe at hpos 100
        strobe_after(100);
        chk("extra_hpos",   hl.hpos,   101);
        chk("extra_err",    hl.err,    1);
        chk("extra_locked", hl.locked, 1);
        strobe_after(109);

        // three consecutive drops lose lock
        e0 = err_seen;
        idle(627);
        chk("drop3_err",    hl.err,        1);
        chk("drop3_errs",   err_seen - e0, 2);
        chk("drop3_locked", hl.locked,     0);
        chk("drop3_hpos",   hl.hpos,       0);

        // periods 209, 210, 210
        drive(1'b1);
        strobe_after(209);
        strobe_after(210);
        chk("p210_first_unlocked", hl.locked, 0);
        strobe_after(210);
        chk("p210_locked", hl.locked,   1);
        chk("p210_len",    hl.line_len, 210);

        // async reset mid-line
        idle(50);
        chk("pre_rst_locked", hl.locked, 1);
        do_reset();

        // short period rejected
        drive(1'b1);
        strobe_after(8);
        strobe_after(209);
        chk("p8_unlocked", hl.locked, 0);
        strobe_after(209);
        chk("p8_then_locked", hl.locked,   1);
        chk("p8_then_len",    hl.line_len, 209);
        idle(627);

        // period exactly MAX_LEN is accepted
        drive(1'b1);
        strobe_after(209);
        strobe_after(1024);
        strobe_after(1024);
        chk("pmax_locked", hl.locked,   1);
        chk("pmax_len",    hl.line_len, 1024);
        idle(3072);

        // one cycle past MAX_LEN times out to SEARCH
        drive(1'b1);
        strobe_after(209);
        strobe_after(1025);
        strobe_after(1024);
        chk("timeout_unlocked", hl.locked, 0);
        strobe_after(1024);
        chk("timeout_relock", hl.locked, 1);
        idle(3072);

        // MIN_LEN boundary
        drive(1'b1);
        repeat (3) strobe_after(15);
        chk("p15_unlocked", hl.locked, 0);
        strobe_after(16);
        strobe_after(16);
        chk("pmin_locked", hl.locked,   1);
        chk("pmin_len",    hl.line_len, 16);
        idle(48);

        // randomized traffic with drops, extra strobes and resets
        for (int it = 0; it < 25; it++) begin
            int p, n, r, k;
            p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 40))
                                            : int'($urandom_range(16, 300));
            n = $urandom_range(2, 5);
            drive(1'b1);
            for (int l = 0; l < n; l++) begin
                r = $urandom_range(0, 15);
                if (r == 0) idle(p);
                else if (r == 1) begin
                    k = $urandom_range(1, p - 1);
                    strobe_after(k);
                    strobe_after(p - k);
                end else strobe_after(p);
            end
            idle($urandom_range(0, 40));
            if ($urandom_range(0, 9) == 0) do_reset();
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
